peri_bus_arbiter: RTL and testbench



---
 rtl/peri_bus_arbiter.sv | 106 ++++++++++
 tb/tb_peri_bus_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter: two-master (CPU m0, DMA m1) peripheral request arbiter, round-robin or fixed m0 priority when ARB_FIXED_PRIO_EN is defined
module peri_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int STRB_W = 4
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [STRB_W-1:0] m0_wmask,
  input  logic              m0_wen,
  input  logic              m0_ren,
  input  logic [2:0]        m0_burst,
  output logic              m0_rvalid,
  output logic              m0_wdone,
  output logic              m0_err,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  input  logic [STRB_W-1:0] m1_wmask,
  input  logic              m1_wen,
  input  logic              m1_ren,
  input  logic [2:0]        m1_burst,
  output logic              m1_rvalid,
  output logic              m1_wdone,
  output logic              m1_err,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] peri_addr,
  output logic [DATA_W-1:0] peri_wdata,
  output logic [STRB_W-1:0] peri_wmask,
  output logic              peri_wen,
  output logic              peri_ren,
  output logic [2:0]        peri_burst,
  input  logic              peri_rvalid,
  input  logic              peri_wdone,
  input  logic              peri_err,
  input  logic [DATA_W-1:0] peri_rdata,
  output logic [1:0]        gnt,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic [4:0] beat_cnt, beat_cnt_nx;
  logic last_gnt, last_gnt_nx;
  logic req0, req1, resp, pick1, g0, g1, own_req;
  function automatic logic [4:0] burst_len(input logic [2:0] b);
    return b == 3'b011 ? 5'd3 : b == 3'b101 ? 5'd7 : b == 3'b111 ? 5'd15 : 5'd0;
  endfunction
  assign req0 = m0_wen | m0_ren;
  assign req1 = m1_wen | m1_ren;
  assign resp = peri_rvalid | peri_wdone;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign own_req = g0 ? req0 : req1;
`ifdef ARB_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
`else
  assign pick1 = req1 & (~req0 | ~last_gnt);
`endif
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= IDLE;
      beat_cnt <= 5'd0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nx;
      beat_cnt <= beat_cnt_nx;
      last_gnt <= last_gnt_nx;
    end
  end
  always_comb begin
    state_nx    = state;
    beat_cnt_nx = beat_cnt;
    last_gnt_nx = last_gnt;
    if (state == IDLE) begin
      if (req0 | req1) begin
        state_nx    = pick1 ? GNT1 : GNT0;
        beat_cnt_nx = burst_len(pick1 ? m1_burst : m0_burst);
        last_gnt_nx = pick1;
      end
    end else if (!own_req || peri_err || (resp && beat_cnt == 5'd0)) begin
      state_nx = IDLE;
    end else if (resp) begin
      beat_cnt_nx = beat_cnt - 5'd1;
    end
  end
  always_comb begin
    peri_addr  = g0 ? m0_addr  : g1 ? m1_addr  : '0;
    peri_wdata = g0 ? m0_wdata : g1 ? m1_wdata : '0;
    peri_wmask = g0 ? m0_wmask : g1 ? m1_wmask : '0;
    peri_burst = g0 ? m0_burst : g1 ? m1_burst : '0;
    peri_wen   = g0 ? m0_wen   : g1 & m1_wen;
    peri_ren   = g0 ? m0_ren   : g1 & m1_ren;
    m0_rvalid  = g0 & peri_rvalid;
    m0_wdone   = g0 & peri_wdone;
    m0_err     = g0 & peri_err;
    m0_rdata   = g0 ? peri_rdata : '0;
    m1_rvalid  = g1 & peri_rvalid;
    m1_wdone   = g1 & peri_wdone;
    m1_err     = g1 & peri_err;
    m1_rdata   = g1 ? peri_rdata : '0;
    gnt        = {g1, g0};
    busy       = g0 | g1;
  end
endmodule

// File: tb/tb_peri_bus_arbiter.sv
// tb_peri_bus_arbiter: scoreboard bench for peri_bus_arbiter
module tb_peri_bus_arbiter;
  logic HCLK = 0, HRESETn = 1;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [3:0] m0_wmask = 0, m1_wmask = 0;
  logic m0_wen = 0, m0_ren = 0, m1_wen = 0, m1_ren = 0;
  logic [2:0] m0_burst = 0, m1_burst = 0;
  logic m0_rvalid, m0_wdone, m0_err, m1_rvalid, m1_wdone, m1_err;
  logic [31:0] m0_rdata, m1_rdata, peri_addr, peri_wdata;
  logic [3:0] peri_wmask;
  logic peri_wen, peri_ren;
  logic [2:0] peri_burst;
  logic peri_rvalid = 0, peri_wdone = 0, peri_err = 0;
  logic [31:0] peri_rdata = 0;
  logic [1:0] gnt;
  logic busy;
  logic [69:0] rq[$];
  logic [1:0] gq[$];
  logic [1:0] seq[6];
  int n_chk = 0, n_fail = 0, k, guard, c0, c1;
  peri_bus_arbiter dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask), .m0_wen(m0_wen), .m0_ren(m0_ren),
    .m0_burst(m0_burst), .m0_rvalid(m0_rvalid), .m0_wdone(m0_wdone), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask), .m1_wen(m1_wen), .m1_ren(m1_ren),
    .m1_burst(m1_burst), .m1_rvalid(m1_rvalid), .m1_wdone(m1_wdone), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .peri_addr(peri_addr), .peri_wdata(peri_wdata), .peri_wmask(peri_wmask), .peri_wen(peri_wen),
    .peri_ren(peri_ren), .peri_burst(peri_burst), .peri_rvalid(peri_rvalid), .peri_wdone(peri_wdone),
    .peri_err(peri_err), .peri_rdata(peri_rdata), .gnt(gnt), .busy(busy)
  );
  always #5 HCLK = ~HCLK;
  function automatic logic [69:0] mk(input bit m, input logic [2:0] kind, input logic [31:0] d);
    return m ? {kind, d, 35'd0} : {35'd0, kind, d};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask
  task automatic monitor();
    logic [1:0] gp;
    logic [69:0] act, exp;
    logic [1:0] ge;
    gp = 0;
    forever begin
      @(negedge HCLK);
      act = {m1_err, m1_wdone, m1_rvalid, m1_rdata, m0_err, m0_wdone, m0_rvalid, m0_rdata};
      if (act[69:67] != 3'b000 || act[34:32] != 3'b000) begin
        n_chk++;
        if (rq.size() == 0) begin
          n_fail++;
          $display("FAIL resp_unexpected: got %h, expected no response", act);
        end else begin
          exp = rq.pop_front();
          if (act !== exp) begin
            n_fail++;
            $display("FAIL resp: got %h, expected %h", act, exp);
          end
        end
      end
      if (gnt != gp && gnt != 2'b00) begin
        n_chk++;
        if (gq.size() == 0) begin
          n_fail++;
          $display("FAIL gnt_unexpected: got %b, expected no grant", gnt);
        end else begin
          ge = gq.pop_front();
          if (gnt !== ge) begin
            n_fail++;
            $display("FAIL gnt_seq: got %b, expected %b", gnt, ge);
          end
        end
      end
      gp = gnt;
    end
  endtask
  task automatic set_req(input bit m, input bit wr, input logic [2:0] b, input logic [31:0] a, input bit on);
    if (!m) begin
      m0_wen = on & wr; m0_ren = on & !wr; m0_burst = b; m0_addr = a; m0_wdata = a ^ 32'h5A5A_5A5A; m0_wmask = 4'hF;
    end else begin
      m1_wen = on & wr; m1_ren = on & !wr; m1_burst = b; m1_addr = a; m1_wdata = a ^ 32'h5A5A_5A5A; m1_wmask = 4'hF;
    end
  endtask
  task automatic do_reset();
    set_req(0, 0, 3'b000, 0, 0);
    set_req(1, 0, 3'b000, 0, 0);
    peri_rvalid = 0; peri_wdone = 0; peri_err = 0; peri_rdata = 0;
    HRESETn = 0;
    tick();
    tick();
    HRESETn = 1;
  endtask
  task automatic do_xfer(input bit m, input logic [2:0] b, input int nb, input bit wr,
                         input logic [31:0] a, input int raise, input int errb);
    logic [1:0] g;
    logic [31:0] d;
    g = m ? 2'b10 : 2'b01;
    set_req(m, wr, b, a, 1);
    gq.push_back(g);
    tick();
    chk("grant", 32'(gnt), 32'(g));
    chk("fwd_en", 32'({peri_wen, peri_ren}), 32'({wr, !wr}));
    chk("fwd_addr", peri_addr, a);
    chk("fwd_burst", 32'(peri_burst), 32'(b));
    for (int i = 0; i < nb; i++) begin
      d = wr ? 32'h0 : 32'hA5A5_0001 + i;
      if (i == errb) begin
        peri_err = 1; rq.push_back(mk(m, 3'b100, 32'h0));
      end else if (wr) begin
        peri_wdone = 1; rq.push_back(mk(m, 3'b010, 32'h0));
      end else begin
        peri_rvalid = 1; peri_rdata = d; rq.push_back(mk(m, 3'b001, d));
      end
      if (i == raise) set_req(!m, 0, 3'b000, 32'h4000_0200, 1);
      tick();
      peri_err = 0; peri_wdone = 0; peri_rvalid = 0; peri_rdata = 0;
      if (i == nb - 1 || i == errb) begin
        set_req(m, wr, b, a, 0);
        chk("release", 32'(gnt), 32'h0);
        break;
      end
      chk("hold", 32'(gnt), 32'(g));
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected summary");
    $fatal(1, "timeout");
  end
  initial begin
    fork
      monitor();
    join_none
    #1 HRESETn = 0;
    m0_ren = 1; m1_wen = 1; peri_rvalid = 1; peri_rdata = 32'hDEAD_BEEF;
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_peri_en", 32'({peri_wen, peri_ren}), 32'h0);
    chk("rst_peri_addr", peri_addr, 32'h0);
    chk("rst_resp", {m1_rvalid, m0_rvalid, m1_rdata[29:0]}, 32'h0);
    do_reset();
    do_xfer(0, 3'b000, 1, 0, 32'h4000_0004, -1, -1);
    do_reset();
`ifdef ARB_FIXED_PRIO_EN
    seq = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10};
`else
    seq = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 6; i++) gq.push_back(seq[i]);
    c0 = 3; c1 = 3; k = 0; guard = 0;
    set_req(0, 1, 3'b000, 32'h4000_0010, 1);
    set_req(1, 1, 3'b000, 32'h4000_0020, 1);
    while (k < 6 && guard < 60) begin
      tick();
      guard++;
      if (busy) begin
        peri_wdone = 1;
        rq.push_back(mk(seq[k] == 2'b10, 3'b010, 32'h0));
        tick();
        peri_wdone = 0;
        chk("rr_idle_gap", 32'(gnt), 32'h0);
        if (seq[k] == 2'b01) begin
          c0--;
          if (c0 == 0) set_req(0, 1, 3'b000, 32'h4000_0010, 0);
        end else begin
          c1--;
          if (c1 == 0) set_req(1, 1, 3'b000, 32'h4000_0020, 0);
        end
        k++;
      end
    end
    chk("rr_done", k, 6);
    do_reset();
    do_xfer(1, 3'b011, 4, 1, 32'h4000_0100, 1, -1);
    do_xfer(0, 3'b000, 1, 0, 32'h4000_0200, -1, -1);
    do_xfer(0, 3'b101, 8, 0, 32'h4000_0300, -1, 2);
    do_xfer(0, 3'b011, 4, 0, 32'h4000_0400, -1, -1);
    set_req(0, 0, 3'b011, 32'h4000_0500, 1);
    gq.push_back(2'b01);
    tick();
    peri_rvalid = 1; peri_rdata = 32'h1111_0001;
    rq.push_back(mk(0, 3'b001, 32'h1111_0001));
    tick();
    peri_rvalid = 0; peri_rdata = 0;
    chk("abandon_hold", 32'(gnt), 32'h1);
    set_req(0, 0, 3'b011, 32'h4000_0500, 0);
    tick();
    chk("abandon_release", 32'(gnt), 32'h0);
    peri_rvalid = 1; peri_rdata = 32'h1111_0002;
    tick();
    peri_rvalid = 0; peri_rdata = 0;
    do_reset();
    set_req(1, 0, 3'b011, 32'h4000_0600, 1);
    gq.push_back(2'b10);
    tick();
    peri_rvalid = 1; peri_rdata = 32'h2222_0001;
    rq.push_back(mk(1, 3'b001, 32'h2222_0001));
    tick();
    peri_rvalid = 0; peri_rdata = 0;
    chk("arst_pre_hold", 32'(gnt), 32'h2);
    #2 HRESETn = 0;
    #1;
    chk("arst_gnt", 32'(gnt), 32'h0);
    chk("arst_ren", 32'(peri_ren), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    set_req(0, 0, 3'b000, 32'h4000_0700, 1);
    tick();
    tick();
    HRESETn = 1;
    peri_rvalid = 1; peri_rdata = 32'h3333_0001;
    gq.push_back(2'b01);
    #1;
    chk("arst_drop_resp", 32'({m1_rvalid, m0_rvalid}), 32'h0);
    tick();
    peri_rvalid = 0; peri_rdata = 0;
    chk("arst_tie_m0", 32'(gnt), 32'h1);
    peri_rvalid = 1; peri_rdata = 32'h3333_0002;
    rq.push_back(mk(0, 3'b001, 32'h3333_0002));
    tick();
    peri_rvalid = 0; peri_rdata = 0;
    set_req(0, 0, 3'b000, 32'h4000_0700, 0);
    set_req(1, 0, 3'b011, 32'h4000_0600, 0);
    chk("arst_final_release", 32'(gnt), 32'h0);
    tick();
    tick();
    chk("rq_empty", rq.size(), 0);
    chk("gq_empty", gq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
